branch_resolve_unit: RTL and testbench

Tracks each fetched instruction's BTB prediction (valid, taken, target) down the IF→ID→EX pipeline. When the instruction reaches EX, it compares that prediction with the actual outcome. From the comparison it drives the BTB's update/mispredict inputs, the front-end redirect and flush, and saturating branch statistics. It closes the prediction loop between the fetch-stage BTB and the execute-stage branch unit.

---
 rtl/branch_resolve_unit.sv | 142 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Carries the BTB prediction made at fetch down IF->ID->EX alongside the
// instruction, checks it against the real outcome in EX, and produces the
// BTB update, the front-end redirect/flush and saturating branch statistics.
module branch_resolve_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_pc,
    input  logic                 if_btb_valid,
    input  logic                 if_btb_taken,
    input  logic [31:0]          if_btb_target,
    input  logic                 pipe_stall,
    input  logic                 ex_branch,
    input  logic                 ex_jump,
    input  logic                 ex_taken,
    input  logic [31:0]          ex_target,
    output logic                 update,
    output logic [31:0]          update_pc,
    output logic [31:0]          update_target,
    output logic                 mispredicted,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic                 flush,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    // Prediction metadata for the instruction in ID
    logic                 idValid_q, idValid_d;
    logic [31:0]          idPc_q, idPc_d;
    logic                 idPt_q, idPt_d;
    logic [31:0]          idTgt_q, idTgt_d;

    // Prediction metadata for the instruction in EX
    logic                 exValid_q, exValid_d;
    logic [31:0]          exPc_q, exPc_d;
    logic                 exPt_q, exPt_d;
    logic [31:0]          exTgt_q, exTgt_d;

    // Statistics counters
    logic [CNT_WIDTH-1:0] brCnt_q, brCnt_d;
    logic [CNT_WIDTH-1:0] misCnt_q, misCnt_d;

    logic                 fetchPt;
    logic                 resolving;
    logic                 actualTaken;
    logic                 mispredict;
    logic                 falseHit;
    logic                 redirectInt;

    // Resolution of the EX instruction against the prediction it carried
    always_comb begin
        fetchPt     = if_btb_valid & if_btb_taken;
        resolving   = exValid_q & (ex_branch | ex_jump);
        actualTaken = ex_jump | ex_taken;
        mispredict  = resolving &
                      ((actualTaken != exPt_q) |
                       (actualTaken & exPt_q & (ex_target != exTgt_q)));
        falseHit    = exValid_q & ~ex_branch & ~ex_jump & exPt_q;
        redirectInt = mispredict | falseHit;

        update        = resolving;
        update_pc     = exPc_q;
        update_target = ex_target;
        mispredicted  = mispredict;
        redirect      = redirectInt;
        flush         = redirectInt;
        redirect_pc   = (resolving & actualTaken) ? ex_target : exPc_q + 32'd4;
    end

    // Pipeline advance: a redirect squashes both stages, a stall holds ID and bubbles EX
    always_comb begin
        idValid_d = idValid_q;
        idPc_d    = idPc_q;
        idPt_d    = idPt_q;
        idTgt_d   = idTgt_q;
        exValid_d = exValid_q;
        exPc_d    = exPc_q;
        exPt_d    = exPt_q;
        exTgt_d   = exTgt_q;
        if (redirectInt) begin
            idValid_d = 1'b0;
            exValid_d = 1'b0;
        end else if (pipe_stall) begin
            exValid_d = 1'b0;
        end else begin
            idValid_d = 1'b1;
            idPc_d    = if_pc;
            idPt_d    = fetchPt;
            idTgt_d   = if_btb_target;
            exValid_d = idValid_q;
            exPc_d    = idPc_q;
            exPt_d    = idPt_q;
            exTgt_d   = idTgt_q;
        end
    end

    // Saturating statistics: stop at all-ones rather than wrapping
    always_comb begin
        brCnt_d  = brCnt_q;
        misCnt_d = misCnt_q;
        if (resolving && (brCnt_q != '1)) begin
            brCnt_d = brCnt_q + CNT_WIDTH'(1);
        end
        if (redirectInt && (misCnt_q != '1)) begin
            misCnt_d = misCnt_q + CNT_WIDTH'(1);
        end
    end

    // State registers; reset drops any in-flight metadata immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idValid_q <= 1'b0;
            idPc_q    <= 32'd0;
            idPt_q    <= 1'b0;
            idTgt_q   <= 32'd0;
            exValid_q <= 1'b0;
            exPc_q    <= 32'd0;
            exPt_q    <= 1'b0;
            exTgt_q   <= 32'd0;
            brCnt_q   <= '0;
            misCnt_q  <= '0;
        end else begin
            idValid_q <= idValid_d;
            idPc_q    <= idPc_d;
            idPt_q    <= idPt_d;
            idTgt_q   <= idTgt_d;
            exValid_q <= exValid_d;
            exPc_q    <= exPc_d;
            exPt_q    <= exPt_d;
            exTgt_q   <= exTgt_d;
            brCnt_q   <= brCnt_d;
            misCnt_q  <= misCnt_d;
        end
    end

    assign branch_count     = brCnt_q;
    assign mispredict_count = misCnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
// Directed scenarios for branch_resolve_unit. Expected EX-stage responses are
// queued when each resolving cycle is driven; a monitor pops and compares
// whenever the DUT presents update or redirect.
module tb_branch_resolve_unit;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [31:0]   ifPc;
    logic          ifBtbValid;
    logic          ifBtbTaken;
    logic [31:0]   ifBtbTarget;
    logic          pipeStall;
    logic          exBranch;
    logic          exJump;
    logic          exTaken;
    logic [31:0]   exTarget;
    logic          update;
    logic [31:0]   updatePc;
    logic [31:0]   updateTarget;
    logic          mispredicted;
    logic          redirect;
    logic [31:0]   redirectPc;
    logic          flush;
    logic [CW-1:0] branchCount;
    logic [CW-1:0] mispredictCount;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        mis;
        logic        red;
        logic        fl;
        logic [31:0] rpc;
    } resp_t;

    resp_t sbq[$];

    branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (ifPc),
        .if_btb_valid     (ifBtbValid),
        .if_btb_taken     (ifBtbTaken),
        .if_btb_target    (ifBtbTarget),
        .pipe_stall       (pipeStall),
        .ex_branch        (exBranch),
        .ex_jump          (exJump),
        .ex_taken         (exTaken),
        .ex_target        (exTarget),
        .update           (update),
        .update_pc        (updatePc),
        .update_target    (updateTarget),
        .mispredicted     (mispredicted),
        .redirect         (redirect),
        .redirect_pc      (redirectPc),
        .flush            (flush),
        .branch_count     (branchCount),
        .mispredict_count (mispredictCount)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectOut(input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                             input logic mis, input logic red, input logic [31:0] rpc);
        resp_t r;
        r.upd  = upd;
        r.upc  = upc;
        r.utgt = utgt;
        r.mis  = mis;
        r.red  = red;
        r.fl   = red;
        r.rpc  = rpc;
        sbq.push_back(r);
    endtask

    // Drive one cycle of fetch and EX inputs, return just after the next rising edge
    task automatic applyStimulus(input logic [31:0] pc, input logic bv, input logic bt, input logic [31:0] btgt,
                                 input logic stall, input logic br, input logic jmp, input logic tk,
                                 input logic [31:0] tgt);
        ifPc        = pc;
        ifBtbValid  = bv;
        ifBtbTaken  = bt;
        ifBtbTarget = btgt;
        pipeStall   = stall;
        exBranch    = br;
        exJump      = jmp;
        exTaken     = tk;
        exTarget    = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic fetchOnly(input logic [31:0] pc);
        applyStimulus(pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic checkCounters(input string tag, input int br, input int mis);
        checkOutput({tag, "_branch_count"}, {28'd0, branchCount}, br[31:0]);
        checkOutput({tag, "_mispredict_count"}, {28'd0, mispredictCount}, mis[31:0]);
    endtask

    // Monitor: every presented update/redirect must match the oldest queued expectation
    always @(negedge clk) begin
        resp_t act;
        resp_t exp;
        if (!rst && (update || redirect)) begin
            act = '{update, updatePc, updateTarget, mispredicted, redirect, flush, redirectPc};
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_output upd=%0b upc=0x%08h red=%0b rpc=0x%08h expected=none",
                         update, updatePc, redirect, redirectPc);
            end else begin
                exp = sbq.pop_front();
                if (act !== exp) begin
                    bad++;
                    $display("[TB] FAIL resp actual upd=%0b upc=0x%08h utgt=0x%08h mis=%0b red=%0b fl=%0b rpc=0x%08h expected upd=%0b upc=0x%08h utgt=0x%08h mis=%0b red=%0b fl=%0b rpc=0x%08h",
                             act.upd, act.upc, act.utgt, act.mis, act.red, act.fl, act.rpc,
                             exp.upd, exp.upc, exp.utgt, exp.mis, exp.red, exp.fl, exp.rpc);
                end
            end
        end
    end

    // Directed scenario sequence
    initial begin
        logic [31:0] base;
        logic [31:0] tg;

        rst         = 1'b1;
        ifPc        = 32'd0;
        ifBtbValid  = 1'b0;
        ifBtbTaken  = 1'b0;
        ifBtbTarget = 32'd0;
        pipeStall   = 1'b0;
        exBranch    = 1'b0;
        exJump      = 1'b0;
        exTaken     = 1'b0;
        exTarget    = 32'h0000_1234;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_update", {31'd0, update}, 32'd0);
        checkOutput("rst_mispredicted", {31'd0, mispredicted}, 32'd0);
        checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_redirect_pc", redirectPc, 32'h4);
        checkOutput("rst_update_pc", updatePc, 32'h0);
        checkOutput("rst_update_target", updateTarget, 32'h1234);
        checkCounters("rst", 0, 0);
        rst = 1'b0;

        // Correct taken prediction
        applyStimulus(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetchOnly(32'h104);
        expectOut(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h200);
        applyStimulus(32'h108, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        checkCounters("taken_ok", 1, 0);

        // BTB miss but branch actually taken
        fetchOnly(32'h40);
        fetchOnly(32'h44);
        expectOut(1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 32'h80);
        applyStimulus(32'h48, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
        checkCounters("miss_taken", 2, 1);
        applyStimulus(32'h80, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h99);
        checkCounters("post_redirect", 2, 1);

        // Jump to a target other than the predicted one
        applyStimulus(32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetchOnly(32'h204);
        expectOut(1'b1, 32'h200, 32'h340, 1'b1, 1'b1, 32'h340);
        applyStimulus(32'h208, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h340);
        checkCounters("wrong_tgt", 3, 2);

        // False hit on a non-branch
        applyStimulus(32'h10, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetchOnly(32'h14);
        expectOut(1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h14);
        fetchOnly(32'h18);
        checkCounters("false_hit", 3, 3);

        // False hit at the top of the address space: fall-through wraps to 0
        applyStimulus(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetchOnly(32'h0);
        expectOut(1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 32'h0);
        fetchOnly(32'h4);
        checkCounters("pc_wrap", 3, 4);

        // One stall cycle mid-flight: bubble in EX, ID metadata resolved a cycle later
        applyStimulus(32'h600, 1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(32'h604, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(32'h604, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700);
        expectOut(1'b1, 32'h600, 32'h700, 1'b0, 1'b0, 32'h700);
        applyStimulus(32'h608, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h700);
        checkCounters("stall", 4, 4);

        // Mispredict while stalled: redirect wins and both stages are invalidated
        fetchOnly(32'h800);
        fetchOnly(32'h804);
        expectOut(1'b1, 32'h800, 32'h900, 1'b1, 1'b1, 32'h900);
        applyStimulus(32'h808, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h900);
        applyStimulus(32'h80C, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h123);
        applyStimulus(32'h810, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h123);
        checkCounters("stall_redirect", 5, 5);

        // Drive both counters past all-ones with repeated taken mispredicts
        for (int i = 0; i < 12; i++) begin
            base = 32'hC00 + 32'(i * 16);
            tg   = 32'hF00 + 32'(i * 16);
            fetchOnly(base);
            fetchOnly(base + 32'd4);
            expectOut(1'b1, base, tg, 1'b1, 1'b1, tg);
            applyStimulus(base + 32'd8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, tg);
        end
        checkCounters("saturate", 15, 15);

        // Asynchronous reset between edges with a false hit sitting in EX
        applyStimulus(32'hA00, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetchOnly(32'hA04);
        exTarget = 32'h55;
        checkOutput("pre_rst_redirect", {31'd0, redirect}, 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_update", {31'd0, update}, 32'd0);
        checkOutput("async_mispredicted", {31'd0, mispredicted}, 32'd0);
        checkOutput("async_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("async_flush", {31'd0, flush}, 32'd0);
        checkOutput("async_redirect_pc", redirectPc, 32'h4);
        checkOutput("async_update_pc", updatePc, 32'h0);
        checkOutput("async_update_target", updateTarget, 32'h55);
        checkCounters("async", 0, 0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(32'hC0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h77);
        fetchOnly(32'hC4);
        checkCounters("after_rst", 0, 0);

        @(negedge clk);
        #1;
        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
